scan_mux: RTL
=============

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter W, default 8: data width per channel, legal range 1..32.
REQ-003 Parameter DWELL, default 4: clock cycles spent on each channel in scan mode, legal range 1..256.
REQ-004 Derived constant SW = max(1, clog2(N_CH)): select/channel index width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 X  input  N_CH*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-008 S  input  SW  channel select, used in manual mode only.
REQ-009 EN  input  1  block enable; 0 freezes all state.
REQ-010 MODE  input  1  0 = manual (S selects), 1 = auto scan.
REQ-011 MASK  input  N_CH  scan-mode channel enable; bit i = 1 includes channel i.
REQ-012 Y  output  W  registered selected data.
REQ-013 Y_VALID  output  1  Y holds data from a legal, enabled channel.
REQ-014 CH  output  SW  index of the channel currently driving Y.
REQ-015 WRAP  output  1  one-cycle pulse when the scan wraps to a lower-or-equal index.

Function
REQ-016 FSM states SHALL be IDLE, MAN, SCAN and EMPTY, with every transition taken on the rising edge of clk.
REQ-017 Transitions: EN=0 -> IDLE from any state; EN=1 and MODE=0 -> MAN; EN=1, MODE=1 and MASK!=0 -> SCAN; EN=1, MODE=1 and MASK=0 -> EMPTY.
REQ-018 Latency SHALL be one cycle: Y at edge k+1 equals the X slice of the channel selected at edge k.
REQ-019 IDLE: Y, CH and dwell counter hold their values; Y_VALID=0; WRAP=0.
REQ-020 MAN: CH<=S and Y<=X[S]; Y_VALID=1 if S<N_CH, else Y<=0 and Y_VALID=0; the dwell counter is held at 0; WRAP=0.
REQ-021 SCAN: the dwell counter counts 0..DWELL-1; CH is unchanged while the count < DWELL-1.
REQ-022 SCAN: at terminal count, CH advances to the next higher index with MASK=1, searching modulo N_CH, and the counter returns to 0.
REQ-023 SCAN: Y<=X[CH] each cycle and Y_VALID=1.
REQ-024 If MASK[CH]=0 while in SCAN, CH SHALL advance to the next enabled channel on the next edge regardless of the dwell count, and the counter SHALL reset to 0.
REQ-025 WRAP SHALL pulse for one cycle, coincident with the new CH, when an advance produces a new index <= the old index.
REQ-026 With exactly one MASK bit set, CH stays constant and WRAP pulses every DWELL cycles.
REQ-027 DWELL=1: CH advances every cycle.
REQ-028 EMPTY: Y<=0; Y_VALID=0; CH holds; the counter resets to 0; WRAP=0.
REQ-029 MAN->SCAN: scan starts from the current CH if that channel is enabled (else REQ-024 applies), with the counter at 0.
REQ-030 SCAN->MAN: S takes effect on the first edge in MAN.
REQ-031 IDLE->previous mode: resumes with the frozen CH and dwell count with no glitch on Y.
REQ-032 MODE, MASK and S changes SHALL be sampled only at clock edges; no combinational path from any input to any output.

Reset
REQ-033 While rst_n=0: Y=0, Y_VALID=0, CH=0, WRAP=0, dwell counter=0, state=IDLE, applied immediately without waiting for a clock edge.
REQ-034 Reset assertion mid-scan or mid-dwell SHALL abort the operation; after deassertion, operation restarts per REQ-017 at the first rising edge.

Verification (N_CH=4, W=8, DWELL=3, X={8'h44,8'h33,8'h22,8'h11})
REQ-035 Manual: EN=1, MODE=0, S=0,1,2,3 one cycle each -> Y=11,22,33,44 each one cycle later, Y_VALID=1, CH follows S delayed by one cycle.
REQ-036 Scan full mask: MODE=1, MASK=4'b1111 from CH=0 -> CH sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; WRAP=1 only on the cycle CH returns to 0.
REQ-037 Sparse mask and live masking: MASK=4'b1010 -> CH 1,1,1,3,3,3,1 with WRAP on each return to 1; clearing MASK[3] mid-dwell on channel 3 -> CH=1 next cycle, counter 0.
REQ-038 Empty and freeze: MASK=0 in scan -> Y=0, Y_VALID=0 next cycle; EN=0 mid-dwell for 5 cycles -> Y, CH and count frozen, Y_VALID=0, scan resumes with the remaining dwell.
REQ-039 Reset mid-scan: rst_n low at the 2nd cycle on channel 2 -> outputs zero immediately without a clock edge; after release with MODE=1, scan restarts at CH=0 with a full dwell.
REQ-040 Parameter sweep: N_CH=3, DWELL=1, MODE=0, S=3 -> Y=0, Y_VALID=0; MODE=1 with full mask -> CH 0,1,2,0 every cycle, WRAP every 3rd cycle.

Source files
------------

// File: rtl/scan_mux.sv
// Channel scanner: selects one of N_CH input slices either by manual select
// or by an automatic masked round-robin with a per-channel dwell time.
module scan_mux #(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   X,
  input  logic [SW-1:0]       S,
  input  logic                EN,
  input  logic                MODE,
  input  logic [N_CH-1:0]     MASK,
  output logic [W-1:0]        Y,
  output logic                Y_VALID,
  output logic [SW-1:0]       CH,
  output logic                WRAP
);

  // state | meaning
  // IDLE  | EN=0, everything frozen, output marked invalid
  // MAN   | channel taken from S every cycle
  // SCAN  | masked round-robin, DWELL cycles per channel
  // EMPTY | scan requested with no channel enabled, output forced to 0

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_TC = CW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MAN, SCAN, EMPTY} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  y_q, y_d;
  logic          sel_ok_q, sel_ok_d;
  logic          wrap_q, wrap_d;

  logic          cur_en;
  logic          hi_found;
  logic [SW-1:0] hi_ch, lo_ch, nxt_ch;
  logic          nxt_wrap;
  logic          s_ok;
  logic [W-1:0]  x_s, x_cur, x_nxt;
  logic          advance;

  // Next enabled channel: lowest enabled index above CH, else lowest enabled overall.
  always_comb begin
    cur_en   = 1'b0;
    hi_found = 1'b0;
    hi_ch    = '0;
    lo_ch    = '0;
    s_ok     = 1'b0;
    x_s      = '0;
    x_cur    = '0;
    for (int j = N_CH - 1; j >= 0; j--) begin
      if (MASK[j]) begin
        lo_ch = SW'(j);
        if (SW'(j) > ch_q) begin
          hi_ch    = SW'(j);
          hi_found = 1'b1;
        end
      end
      if (SW'(j) == ch_q) begin
        cur_en = MASK[j];
        x_cur  = X[j*W +: W];
      end
      if (SW'(j) == S) begin
        s_ok = 1'b1;
        x_s  = X[j*W +: W];
      end
    end
    nxt_ch   = hi_found ? hi_ch : lo_ch;
    nxt_wrap = ~hi_found;
  end

  always_comb begin
    x_nxt = '0;
    for (int j = 0; j < N_CH; j++) begin
      if (SW'(j) == nxt_ch) x_nxt = X[j*W +: W];
    end
  end

  always_comb begin
    if (!EN)              state_d = IDLE;
    else if (!MODE)       state_d = MAN;
    else if (MASK == '0)  state_d = EMPTY;
    else                  state_d = SCAN;

    ch_d     = ch_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    sel_ok_d = sel_ok_q;
    wrap_d   = 1'b0;
    advance  = ~cur_en | (cnt_q == CNT_TC);

    unique case (state_d)
      IDLE: ;
      MAN: begin
        ch_d     = S;
        cnt_d    = '0;
        sel_ok_d = s_ok;
        y_d      = x_s;
      end
      SCAN: begin
        sel_ok_d = 1'b1;
        if (advance) begin
          ch_d   = nxt_ch;
          cnt_d  = '0;
          wrap_d = nxt_wrap;
          y_d    = x_nxt;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          y_d    = x_cur;
        end
      end
      EMPTY: begin
        y_d      = '0;
        cnt_d    = '0;
        sel_ok_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      sel_ok_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      sel_ok_q <= sel_ok_d;
      wrap_q   <= wrap_d;
    end
  end

  assign Y       = y_q;
  assign CH      = ch_q;
  assign WRAP    = wrap_q;
  assign Y_VALID = (state_q == SCAN) | ((state_q == MAN) & sel_ok_q);

endmodule
